// File: rtl/spell_dbg_pkg.sv
// rtl/spell_dbg_pkg.sv - shared types and constants for the SPELL debug host
package spell_dbg_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_STEP  = 2'd2,
        OP_RUN   = 2'd3
    } op_e;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DUMP     = 3'd1;
    localparam logic [2:0] ST_SHIFT_RD = 3'd2;
    localparam logic [2:0] ST_SHIFT_WR = 3'd3;
    localparam logic [2:0] ST_LOAD     = 3'd4;
    localparam logic [2:0] ST_PULSE    = 3'd5;
    localparam logic [2:0] ST_RESP     = 3'd6;

    localparam logic [1:0] REG_SEL_0 = 2'd0;
    localparam logic [1:0] REG_SEL_1 = 2'd1;
    localparam logic [1:0] REG_SEL_2 = 2'd2;
    localparam logic [1:0] REG_SEL_3 = 2'd3;

    // First FSM state entered when a command of the given op is accepted.
    function automatic logic [2:0] first_state(input op_e op);
        case (op)
            OP_READ:  first_state = ST_DUMP;
            OP_WRITE: first_state = ST_SHIFT_WR;
            default:  first_state = ST_PULSE;
        endcase
    endfunction

endpackage

// File: rtl/spell_dbg_shifter.sv
// rtl/spell_dbg_shifter.sv - bit counter plus parallel/serial shift register
module spell_dbg_shifter
    import spell_dbg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] par_in,
    input  logic              shift_en,
    input  logic              ser_in,
    output logic              ser_out,
    output logic [DATA_W-1:0] par_out,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;

    // Parallel load restarts the count; each shift moves one bit MSB-first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= par_in;
            cnt <= CNT_MAX;
        end else if (shift_en) begin
            sr  <= {sr[DATA_W-2:0], ser_in};
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign ser_out = sr[DATA_W-1];
    assign par_out = sr;
    assign done    = (cnt == '0);

endmodule

// File: rtl/spell_dbg_host.sv
// rtl/spell_dbg_host.sv - host command to SPELL serial control pin sequencer
module spell_dbg_host
    import spell_dbg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_reg,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              o_run,
    output logic              o_step,
    output logic              o_load,
    output logic              o_dump,
    output logic              o_shift_in,
    output logic [1:0]        o_reg_sel,
    input  logic              i_cpu_sleep,
    input  logic              i_cpu_stop,
    input  logic              i_shift_out
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    op_e               op_q;
    logic [1:0]        reg_q;
    logic              run_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_now;
    logic [DATA_W-1:0] status;
    logic              accept;
    logic              sh_load;
    logic [DATA_W-1:0] sh_par_in;
    logic              sh_shift;
    logic              sh_ser_out;
    logic [DATA_W-1:0] sh_par_out;
    logic              sh_done;

    assign accept    = cmd_valid && cmd_ready;
    assign sh_load   = accept;
    assign sh_par_in = (op_e'(cmd_op) == OP_WRITE) ? cmd_wdata : '0;
    assign sh_shift  = (state == ST_SHIFT_RD) || (state == ST_SHIFT_WR);

    spell_dbg_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .par_in   (sh_par_in),
        .shift_en (sh_shift),
        .ser_in   (i_shift_out),
        .ser_out  (sh_ser_out),
        .par_out  (sh_par_out),
        .done     (sh_done)
    );

    // Next-state decode; shift states leave once the bit counter reaches zero.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept) state_nxt = first_state(op_e'(cmd_op));
            ST_DUMP:     state_nxt = ST_SHIFT_RD;
            ST_SHIFT_RD: if (sh_done) state_nxt = ST_RESP;
            ST_SHIFT_WR: if (sh_done) state_nxt = ST_LOAD;
            ST_LOAD:     state_nxt = ST_RESP;
            ST_PULSE:    state_nxt = ST_RESP;
            ST_RESP:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // CPU status word reported for every op other than READ.
    always_comb begin
        status    = '0;
        status[1] = i_cpu_stop;
        status[0] = i_cpu_sleep;
    end

    // Response data: live during RESP, held afterwards until the next RESP.
    always_comb begin
        rdata_now = rdata_q;
        if (state == ST_RESP) begin
            rdata_now = (op_q == OP_READ) ? sh_par_out : status;
        end
    end

    // FSM state, latched command fields, run level and held response data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_READ;
            reg_q   <= REG_SEL_0;
            run_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op_e'(cmd_op);
                reg_q <= cmd_reg;
                // Updating at acceptance makes the new run level visible in the PULSE cycle.
                if (op_e'(cmd_op) == OP_RUN) begin
                    run_q <= cmd_wdata[0];
                end
            end
            if (state == ST_RESP) begin
                rdata_q <= rdata_now;
            end
        end
    end

    // Outputs are gated by reset so an aborted sequence is silenced in the reset cycle itself.
    assign cmd_ready  = rst_n && (state == ST_IDLE);
    assign rsp_valid  = rst_n && (state == ST_RESP);
    assign rsp_rdata  = rst_n ? rdata_now : '0;
    assign o_run      = rst_n && run_q;
    assign o_step     = rst_n && (state == ST_PULSE) && (op_q == OP_STEP);
    assign o_load     = rst_n && (state == ST_LOAD);
    assign o_dump     = rst_n && (state == ST_DUMP);
    assign o_shift_in = rst_n && (state == ST_SHIFT_WR) && sh_ser_out;
    assign o_reg_sel  = (rst_n && (state != ST_IDLE)) ? reg_q : REG_SEL_0;

endmodule

// File: tb/tb_spell_dbg_host.sv
// tb/tb_spell_dbg_host.sv - self-checking bench for spell_dbg_host
module tb_spell_dbg_host;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [1:0]   cmd_reg = 2'd0;
    logic [W-1:0] cmd_wdata = '0;
    logic         rsp_valid;
    logic [W-1:0] rsp_rdata;
    logic         o_run, o_step, o_load, o_dump, o_shift_in;
    logic [1:0]   o_reg_sel;
    logic         i_cpu_sleep = 1'b0;
    logic         i_cpu_stop = 1'b0;
    logic         i_shift_out;

    logic [W-1:0] cpu_regs [4];
    logic [W-1:0] cpu_sr = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [W-1:0] exp_data [$];
    int           exp_cyc [$];
    int           rsp_cyc [$];

    spell_dbg_host #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_reg     (cmd_reg),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .o_run       (o_run),
        .o_step      (o_step),
        .o_load      (o_load),
        .o_dump      (o_dump),
        .o_shift_in  (o_shift_in),
        .o_reg_sel   (o_reg_sel),
        .i_cpu_sleep (i_cpu_sleep),
        .i_cpu_stop  (i_cpu_stop),
        .i_shift_out (i_shift_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // CPU serial control model: dump/load on the selected register, shift left otherwise.
    always @(posedge clk) begin
        if (o_dump) cpu_sr <= cpu_regs[o_reg_sel];
        else        cpu_sr <= {cpu_sr[W-2:0], o_shift_in};
        if (o_load) cpu_regs[o_reg_sel] <= cpu_sr;
    end
    assign i_shift_out = cpu_sr[W-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response scoreboard: pop expected data and cycle on each rsp_valid.
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cyc.push_back(cyc);
            n_vec++;
            assert (exp_data.size() != 0) else begin
                n_err++;
                $error("FAIL rsp_unexpected: observed rsp_valid at cycle %0d expected none", cyc);
            end
            if (exp_data.size() != 0) begin
                logic [W-1:0] ed;
                int ec;
                ed = exp_data.pop_front();
                ec = exp_cyc.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(ed));
                chk("rsp_cycle", cyc, ec);
            end
        end
        if (rst_n) begin
            chk("pulse_exclusive", 32'(o_load) + 32'(o_dump) + 32'(o_step) <= 1, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait for acceptance, schedule its expected response.
    task automatic issue(input logic [1:0] op, input logic [1:0] rg, input logic [W-1:0] wd,
                         input logic [W-1:0] exp_rd, input int lat, input bit expect_rsp);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = rg;
        cmd_wdata = wd;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) break;
            step();
        end
        chk("accept_ready", 32'(cmd_ready), 1);
        if (expect_rsp) begin
            exp_data.push_back(exp_rd);
            exp_cyc.push_back(cyc + lat);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_data.size() == 0) break;
            step();
        end
        chk("rsp_drain", exp_data.size(), 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] wd;
        int ns, acc, nlow, cnt_bad, cnt_rsp;
        cpu_regs[0] = 8'h5A;
        cpu_regs[1] = 8'h00;
        cpu_regs[2] = 8'h3C;
        cpu_regs[3] = 8'h00;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_outputs", 32'({rsp_valid, o_run, o_step, o_load, o_dump, o_shift_in, o_reg_sel}), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_run", 32'(o_run), 0);

        // WRITE reg 1 = 0xA5
        wd = 8'hA5;
        issue(2'd1, 2'd1, wd, 8'h00, 10, 1'b1);
        for (int i = 0; i < W; i++) begin
            chk("wr_shift_in", 32'(o_shift_in), 32'(wd[W-1-i]));
            chk("wr_reg_sel", 32'(o_reg_sel), 1);
            chk("wr_no_load", 32'(o_load), 0);
            step();
        end
        chk("wr_load", 32'(o_load), 1);
        drain();
        chk("wr_cpu_reg1", 32'(cpu_regs[1]), 32'h A5);

        // READ reg 2 then reg 1
        issue(2'd0, 2'd2, '0, 8'h3C, 10, 1'b1);
        chk("rd_dump", 32'(o_dump), 1);
        chk("rd_reg_sel", 32'(o_reg_sel), 2);
        step();
        chk("rd_dump_off", 32'(o_dump), 0);
        drain();
        issue(2'd0, 2'd1, '0, 8'hA5, 10, 1'b1);
        drain();

        // RUN on, STEP with stop asserted, RUN off with sleep asserted
        issue(2'd3, 2'd0, 8'h01, 8'h00, 2, 1'b1);
        chk("run_on", 32'(o_run), 1);
        drain();
        i_cpu_stop = 1'b1;
        issue(2'd2, 2'd0, '0, 8'h02, 2, 1'b1);
        ns = 0;
        for (int i = 0; i < 6; i++) begin
            ns += int'(o_step);
            step();
        end
        chk("step_pulses", ns, 1);
        chk("run_held", 32'(o_run), 1);
        drain();
        i_cpu_stop  = 1'b0;
        i_cpu_sleep = 1'b1;
        issue(2'd3, 2'd0, 8'hFE, 8'h01, 2, 1'b1);
        chk("run_off", 32'(o_run), 0);
        drain();
        i_cpu_sleep = 1'b0;

        // Three back-to-back READs with cmd_valid held high
        rsp_cyc.delete();
        acc = 0;
        nlow = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_reg   = 2'd0;
        for (int i = 0; i < 60; i++) begin
            if (acc == 3) break;
            if (cmd_ready) begin
                exp_data.push_back((acc == 0) ? 8'h5A : (acc == 1) ? 8'hA5 : 8'h3C);
                exp_cyc.push_back(cyc + 10);
                acc++;
                step();
                cmd_reg = 2'(acc);
            end else begin
                nlow++;
                step();
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", acc, 3);
        chk("b2b_ready_low", nlow, 20);
        drain();
        chk("b2b_rsp_count", rsp_cyc.size(), 3);
        if (rsp_cyc.size() == 3) begin
            chk("b2b_gap_1", rsp_cyc[1] - rsp_cyc[0], 11);
            chk("b2b_gap_2", rsp_cyc[2] - rsp_cyc[1], 11);
        end

        // Reset in the middle of a WRITE
        issue(2'd3, 2'd0, 8'h01, 8'h00, 2, 1'b1);
        drain();
        issue(2'd1, 2'd2, 8'hFF, 8'h00, 10, 1'b0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({rsp_valid, o_run, o_step, o_load, o_dump, o_shift_in, o_reg_sel}), 0);
        chk("abort_ready", 32'(cmd_ready), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("abort_ready_after", 32'(cmd_ready), 1);
        cnt_bad = 0;
        cnt_rsp = 0;
        for (int i = 0; i < 12; i++) begin
            cnt_bad += int'(o_load) + int'(o_dump) + int'(o_step);
            cnt_rsp += int'(rsp_valid);
            step();
        end
        chk("abort_no_pulses", cnt_bad, 0);
        chk("abort_no_rsp", cnt_rsp, 0);
        chk("abort_run_off", 32'(o_run), 0);
        chk("abort_cpu_reg2", 32'(cpu_regs[2]), 32'h3C);

        // Inputs changed after acceptance must not affect the operation
        wd = 8'hC3;
        issue(2'd1, 2'd3, wd, 8'h00, 10, 1'b1);
        cmd_wdata = 8'hFF;
        cmd_reg   = 2'd0;
        cmd_op    = 2'd2;
        for (int i = 0; i < W; i++) begin
            chk("latch_shift_in", 32'(o_shift_in), 32'(wd[W-1-i]));
            chk("latch_reg_sel", 32'(o_reg_sel), 3);
            step();
        end
        chk("latch_load", 32'(o_load), 1);
        drain();
        issue(2'd0, 2'd3, '0, 8'hC3, 10, 1'b1);
        drain();

        chk("scoreboard_empty", exp_data.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spell_dbg_host.md
# spell_dbg_host

Host-side debug master for the SPELL CPU serial control interface. It converts single-word host commands (register read, register write, single step, run on/off) into the cycle-exact run/step/load/dump/shift_in/reg_sel pin sequences the CPU expects, and reassembles the CPU's shift_out stream into read data. It sits between a host bus (or an on-chip test controller) and the CPU's `ui_in`/`uo_out` control pins, in the same clock domain as the CPU.

## Interface
Parameters:
- `DATA_W`, default 8: shift word width; must match the CPU shift register.

Ports:
- `clk`  in  1: clock shared with the CPU.
- `rst_n`  in  1: synchronous, active-low reset.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: high only in IDLE; command accepted on `cmd_valid && cmd_ready`.
- `cmd_op`  in  2: 0 READ, 1 WRITE, 2 STEP, 3 RUN.
- `cmd_reg`  in  2: CPU register select for READ/WRITE.
- `cmd_wdata`  in  DATA_W: WRITE data; bit 0 is the run level for RUN.
- `rsp_valid`  out  1: one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  DATA_W: READ result; for other ops `{0…, cpu_stop, cpu_sleep}`.
- `o_run`, `o_step`, `o_load`, `o_dump`, `o_shift_in`  out  1 each: to CPU `ui_in[0..4]`.
- `o_reg_sel`  out  2: to CPU `ui_in[6:5]`.
- `i_cpu_sleep`, `i_cpu_stop`, `i_shift_out`  in  1 each: from CPU `uo_out[0]`, `uo_out[1]`, `uo_out[3]`.

## Operation
- CPU-side protocol: the CPU shift register shifts left every clock, taking `shift_in` at LSB; `shift_out` is its MSB. `dump` copies the selected register into the shift register; `load` copies the shift register into the selected register.
- States: IDLE, DUMP, SHIFT_RD, SHIFT_WR, LOAD, PULSE, RESP.
- READ: IDLE → DUMP (`o_dump`=1, 1 cycle) → SHIFT_RD (DATA_W cycles, sample `i_shift_out` MSB first, `o_shift_in`=0) → RESP.
- WRITE: IDLE → SHIFT_WR (DATA_W cycles, drive `cmd_wdata` MSB first on `o_shift_in`) → LOAD (`o_load`=1, 1 cycle) → RESP.
- STEP: IDLE → PULSE (`o_step`=1, 1 cycle) → RESP. Issued regardless of `o_run`.
- RUN: IDLE → PULSE (`o_run` ← `cmd_wdata[0]`, registered, held until next RUN or reset) → RESP.
- RESP: `rsp_valid`=1 for one cycle, then IDLE.
- Command fields latched at acceptance; input changes after acceptance have no effect.
- `o_reg_sel` driven from latched `cmd_reg` from DUMP/SHIFT_WR entry through RESP; 0 in IDLE.
- `rsp_rdata` holds its value until the next RESP.
- Bit counter: $clog2(DATA_W) bits, counts DATA_W-1 down to 0; exit shift state on 0.

## Timing
- Reset values: `cmd_ready`=0 during reset, 1 the first cycle after; all other outputs 0, including `o_run` and `rsp_rdata`.
- Cycle A = acceptance edge. READ: `o_dump` in A+1, bits sampled at the ends of A+2..A+1+DATA_W, `rsp_valid` at A+2+DATA_W (A+10 for DATA_W=8).
- WRITE: `o_shift_in`=wdata[DATA_W-1] in A+1 … wdata[0] in A+DATA_W, `o_load` in A+DATA_W+1, `rsp_valid` A+DATA_W+2.
- STEP/RUN: pulse or `o_run` update in A+1, `rsp_valid` in A+2.
- Next acceptance no earlier than the cycle after `rsp_valid`.
- Status bits in `rsp_rdata` for STEP/RUN are sampled in the RESP cycle.
- Reset mid-operation: abort immediately; no `rsp_valid`; `o_load`/`o_dump`/`o_step` never asserted after reset; `o_run`=0.
- Only one of `o_load`, `o_dump`, `o_step` high in any cycle.

## Structure
- `spell_dbg_pkg`: op enum (READ/WRITE/STEP/RUN), state enum, register-select constants, `DATA_W` default.
- Sub-module `spell_dbg_shifter`: bit counter plus parallel/serial shift register (load, shift-out, shift-in, done); FSM in `spell_dbg_host`.

## Test plan
- Reset, then WRITE reg 1 = 0xA5 → `o_shift_in` sequence 1,0,1,0,0,1,0,1 in A+1..A+8, `o_load` at A+9, `rsp_valid` at A+10.
- CPU model holding 0x3C in reg 2, READ reg 2 → `o_dump` at A+1, `rsp_rdata`=0x3C with `rsp_valid` at A+10.
- RUN wdata=1 → `o_run`=1 from A+1; STEP then → single `o_step` pulse; with `i_cpu_stop`=1, `i_cpu_sleep`=0 `rsp_rdata`=0x02.
- `cmd_valid` held high for 3 back-to-back READs → `cmd_ready` low during each operation, exactly 3 `rsp_valid` pulses, 11 cycles apart.
- Assert `rst_n`=0 at A+4 of a WRITE → no `o_load`, no `rsp_valid`, all outputs 0; next cycle after release `cmd_ready`=1.
- Change `cmd_wdata`/`cmd_reg` after acceptance → shifted data and `o_reg_sel` reflect latched values.
